// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, LATENCY wait cycles,
// byte-enable stores, and a registered load/ack response held until accepted.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
    localparam logic [7:0]  LAT_L   = 8'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic          accept;
    logic          commit;
    logic          addr_err;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;

    assign accept   = (state_q == S_IDLE) && req_valid_i;
    assign commit   = (state_q == S_WAIT) && (cnt_q == LAT_L);
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_L);
    assign word_idx = addr_q[AW+1:2];

    // One byte-wide array per lane so each byte enable is a plain write enable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH_WORDS];

            always_ff @(posedge clk_i) begin
                if (commit && write_q && !addr_err && be_q[gi]) begin
                    mem_q[word_idx] <= wdata_q[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = mem_q[word_idx];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (commit) begin
                    state_d = S_RESP;
                    err_d   = addr_err;
                    rdata_d = (addr_err || write_q) ? 32'd0 : rd_word;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a word-array model
// (LATENCY=2 instance for data paths, LATENCY=0 instance for throughput).
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;
    localparam int INITW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=2 instance
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    // LATENCY=0 instance
    logic        req_valid0 = 1'b0, resp_ready0 = 1'b0;
    logic [31:0] req_wdata0 = '0;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0),
        .req_write_i(1'b1), .req_addr_i(32'h0),
        .req_wdata_i(req_wdata0), .req_be_i(4'hF),
        .resp_valid_o(resp_valid0), .resp_ready_i(resp_ready0),
        .resp_rdata_o(resp_rdata0), .resp_err_o(resp_err0)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction on the LATENCY=2 instance with `hold` cycles of response backpressure.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int hold);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          lat;
        exp_err = (a % 4 != 0) || (a / 4 >= DEPTH);
        exp_rd  = 32'd0;
        if (!exp_err && !w) exp_rd = model[a/4];
        if (!exp_err && w)
            for (int b = 0; b < 4; b++)
                if (be[b]) model[a/4][8*b +: 8] = d[8*b +: 8];

        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_addr = $urandom;
        req_wdata = $urandom; req_be = 4'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!resp_valid && lat < 300);
        check("latency", lat, LAT + 1);
        check("rdata", resp_rdata, exp_rd);
        check("err", {31'd0, resp_err}, {31'd0, exp_err});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, exp_rd);
            check("bp_err", {31'd0, resp_err}, {31'd0, exp_err});
            check("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'(($urandom % 2));
        @(negedge clk);
        check("post_valid", {31'd0, resp_valid}, 32'd0);
        check("post_ready", {31'd0, req_ready}, 32'd1);
        check("post_rdata", resp_rdata, 32'd0);
        check("post_err", {31'd0, resp_err}, 32'd0);
        resp_ready = 1'b0;
        $display("txn w=%0d addr=%h wdata=%h be=%b -> rdata=%h err=%0d lat=%0d",
                 w, a, d, be, resp_rdata, exp_err, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;

        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_ready0", {31'd0, req_ready0}, 32'd1);
        check("rst_valid0", {31'd0, resp_valid0}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < INITW; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

        // Store then load back
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("load_10", model[4], 32'hDEADBEEF);

        // Partial byte enables
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
        txn(1'b0, 32'h20, 32'h0, 4'hF, 0);
        check("be_merge_model", model[8], 32'h11BB33DD);

        // Misaligned / out-of-range accesses
        txn(1'b0, 32'h22, 32'h0, 4'h0, 0);
        txn(1'b0, 32'h400, 32'h0, 4'h0, 0);
        txn(1'b1, 32'h401, 32'hFFFFFFFF, 4'hF, 0);
        txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 0);
        txn(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 0);

        // Response backpressure
        txn(1'b0, 32'h10, 32'h0, 4'h0, 5);
        txn(1'b1, 32'h14, 32'h0BADF00D, 4'b1001, 5);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, INITW - 1)) * 4;
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'($urandom_range(DEPTH, 4 * DEPTH)) * 4;
            txn(1'($urandom % 2), a, $urandom, 4'($urandom), $urandom_range(0, 2));
        end

        // LATENCY=0, requests held and responses always accepted: period of 3
        @(negedge clk);
        req_valid0 = 1'b1; resp_ready0 = 1'b1; req_wdata0 = $urandom;
        for (int i = 0; i < 12; i++) begin
            check("l0_ready", {31'd0, req_ready0}, (i % 3 == 0) ? 32'd1 : 32'd0);
            check("l0_valid", {31'd0, resp_valid0}, (i % 3 == 2) ? 32'd1 : 32'd0);
            if (i % 3 == 2) check("l0_err", {31'd0, resp_err0}, 32'd0);
            $display("lat0 cycle=%0d ready=%0d valid=%0d", i, req_ready0, resp_valid0);
            @(negedge clk);
        end
        req_valid0 = 1'b0; resp_ready0 = 1'b0;

        // Reset during WAIT aborts the store
        txn(1'b1, 32'h30, 32'h0, 4'hF, 0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
        req_wdata = 32'h55555555; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("wait_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'd0);
        check("mid_rst_err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 32'h30, 32'h0, 4'h0, 0);
        check("abort_model", model[12], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
